// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared definitions for the pipeline hazard/control unit: stage indices,
// serialize FSM encoding and default-width stall/flush vector types.
package pipe_ctrl_gen_pkg;

    localparam int STAGES_DEF = 5;

    localparam int IF_IDX_C = 0;
    localparam int ID_IDX_C = 1;
    localparam int EX_IDX_C = 2;
    localparam int MM_IDX_C = 3;
    localparam int WB_IDX_C = 4;

    localparam int LU_CNT_W = 3;

    localparam logic [1:0] SER_IDLE    = 2'd0;
    localparam logic [1:0] SER_DRAIN   = 2'd1;
    localparam logic [1:0] SER_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = SER_IDLE,
        ST_DRAIN   = SER_DRAIN,
        ST_RELEASE = SER_RELEASE
    } ser_state_t;

    typedef logic [STAGES_DEF-1:0] stall_t;
    typedef logic [STAGES_DEF-1:0] flush_t;

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Pipeline-to-controller bundle: per-stage requests and hazard operands in,
// per-stage hold/kill/bubble controls out.
interface pipe_ctrl_gen_if #(
    parameter int STAGES    = 5,
    parameter int ISSUE_NUM = 2
);
    logic [STAGES-1:0]         stall_req;
    logic [STAGES-1:0]         flush_req;
    logic [STAGES-1:0]         valid;
    logic [ISSUE_NUM-1:0]      id_rs1_en;
    logic [ISSUE_NUM-1:0]      id_rs2_en;
    logic [ISSUE_NUM-1:0][4:0] id_rs1;
    logic [ISSUE_NUM-1:0][4:0] id_rs2;
    logic [ISSUE_NUM-1:0]      ex_mem_read;
    logic [ISSUE_NUM-1:0][4:0] ex_rd;
    logic                      id_serialize;
    logic [STAGES-1:0]         stall;
    logic [STAGES-1:0]         flush;
    logic [STAGES-1:0]         bubble;

    modport master (
        output stall_req, flush_req, valid, id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               ex_mem_read, ex_rd, id_serialize,
        input  stall, flush, bubble
    );

    modport slave (
        input  stall_req, flush_req, valid, id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               ex_mem_read, ex_rd, id_serialize,
        output stall, flush, bubble
    );
endinterface

// File: rtl/pipe_ctrl_gen_lu_detect.sv
// Load-use comparator: any EX load lane whose nonzero rd matches an enabled
// source of any ID lane raises o_lu_hit.
module pipe_lu_detect #(
    parameter int ISSUE_NUM = 2
) (
    input  logic [ISSUE_NUM-1:0]      i_rs1_en,
    input  logic [ISSUE_NUM-1:0]      i_rs2_en,
    input  logic [ISSUE_NUM-1:0][4:0] i_rs1,
    input  logic [ISSUE_NUM-1:0][4:0] i_rs2,
    input  logic [ISSUE_NUM-1:0]      i_mem_read,
    input  logic [ISSUE_NUM-1:0][4:0] i_rd,
    output logic                      o_lu_hit
);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
        o_lu_hit = 1'b0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            for (int l = 0; l < ISSUE_NUM; l++) begin
                if (i_mem_read[i] && (i_rd[i] != 5'd0) &&
                    ((i_rs1_en[l] && (i_rs1[l] == i_rd[i])) ||
                     (i_rs2_en[l] && (i_rs2[l] == i_rd[i])))) begin
                    o_lu_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/control unit: oldest-wins flush, per-stage stalls, load-use
// interlock and serialize drain. PIPE_CTRL_PERF_EN adds saturating perf counters.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int STAGES    = STAGES_DEF,
    parameter int ISSUE_NUM = 2,
    parameter int ID_IDX    = ID_IDX_C,
    parameter int EX_IDX    = EX_IDX_C,
    parameter int LU_LAT    = 1
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ctrl_gen_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
    , output logic [CNT_W-1:0] perf_stall_cyc
    , output logic [CNT_W-1:0] perf_flush_evt
    , output logic [CNT_W-1:0] perf_lu_evt
`endif
);

    localparam logic [LU_CNT_W-1:0] LU_LOAD = LU_CNT_W'(LU_LAT - 1);

    logic [LU_CNT_W-1:0] r_lu_cnt;
    ser_state_t          r_ser_state;

    logic              w_lu_hit;
    logic [STAGES-1:0] w_kill_above;
    logic [STAGES-1:0] w_se;
    logic              w_id_kill;
    logic              w_older_valid;
    logic              w_lu_live;
    logic              w_lu_start;
    logic              w_id_stall;

    pipe_lu_detect #(.ISSUE_NUM(ISSUE_NUM)) u_lu_detect (
        .i_rs1_en   (bus.id_rs1_en),
        .i_rs2_en   (bus.id_rs2_en),
        .i_rs1      (bus.id_rs1),
        .i_rs2      (bus.id_rs2),
        .i_mem_read (bus.ex_mem_read),
        .i_rd       (bus.ex_rd),
        .o_lu_hit   (w_lu_hit)
    );

    // w_kill_above[m]: some older stage redirects, so stage m holds a dead instruction.
    always_comb begin
        logic acc_kill;
        logic acc_valid;
        acc_kill      = 1'b0;
        acc_valid     = 1'b0;
        w_kill_above  = '0;
        w_older_valid = 1'b0;
        for (int m = STAGES - 1; m >= 0; m--) begin
            w_kill_above[m] = acc_kill;
            acc_kill        = acc_kill | bus.flush_req[m];
            if (m == ID_IDX) w_older_valid = acc_valid;
            acc_valid       = acc_valid | bus.valid[m];
        end
    end

    assign w_id_kill  = w_kill_above[ID_IDX];
    assign w_lu_live  = w_lu_hit & ~w_kill_above[EX_IDX];
    assign w_lu_start = (r_lu_cnt == '0) & w_lu_live & ~w_id_kill;
    assign w_id_stall = (r_lu_cnt != '0) | w_lu_live
                      | (r_ser_state == ST_DRAIN)
                      | ((r_ser_state == ST_IDLE) & bus.id_serialize & w_older_valid);

    always_comb begin
        logic acc_stall;
        acc_stall  = 1'b0;
        w_se       = '0;
        bus.stall  = '0;
        bus.flush  = '0;
        bus.bubble = '0;
        for (int m = 0; m < STAGES; m++) begin
            w_se[m] = (bus.stall_req[m] | ((m == ID_IDX) & w_id_stall)) & ~w_kill_above[m];
        end
        for (int j = STAGES - 1; j >= 0; j--) begin
            acc_stall    = acc_stall | w_se[j];
            bus.stall[j] = acc_stall;
            bus.flush[j] = w_kill_above[j];
        end
        for (int j = 1; j < STAGES; j++) begin
            bus.bubble[j] = bus.stall[j-1] & ~bus.stall[j];
        end
        if (rst) begin
            bus.stall  = '1;
            bus.flush  = '1;
            bus.bubble = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking '<=' with a synchronous reset checked first.
        if (rst) begin
            r_lu_cnt    <= '0;
            r_ser_state <= ST_IDLE;
        end else begin
            if (r_lu_cnt != '0) r_lu_cnt <= r_lu_cnt - LU_CNT_W'(1);
            else if (w_lu_start) r_lu_cnt <= LU_LOAD;

            if (w_id_kill) begin
                r_ser_state <= ST_IDLE;
            end else begin
                case (r_ser_state)
                    ST_IDLE:    if (bus.id_serialize && w_older_valid) r_ser_state <= ST_DRAIN;
                    ST_DRAIN:   if (!w_older_valid) r_ser_state <= ST_RELEASE;
                    ST_RELEASE: r_ser_state <= ST_IDLE;
                    default:    r_ser_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;
    logic [CNT_W-1:0] r_perf_lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_lu    <= '0;
        end else begin
            if (bus.stall[ID_IDX] && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + CNT_W'(1);
            if ((|bus.flush_req) && !(&r_perf_flush))  r_perf_flush <= r_perf_flush + CNT_W'(1);
            if (w_lu_start && !(&r_perf_lu))           r_perf_lu    <= r_perf_lu + CNT_W'(1);
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_flush_evt = r_perf_flush;
    assign perf_lu_evt    = r_perf_lu;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: two instances (LU_LAT=1 and 3) driven
// identically, compared each cycle against a behavioural model.
module tb_pipe_ctrl_gen;
    import pipe_ctrl_gen_pkg::*;

    localparam int NS    = 5;
    localparam int NI    = 2;
    localparam int IDI   = 1;
    localparam int EXI   = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stall_t              stall_req;
    flush_t              flush_req;
    logic [NS-1:0]       valid;
    logic [NI-1:0]       id_rs1_en, id_rs2_en, ex_mem_read;
    logic [NI-1:0][4:0]  id_rs1, id_rs2, ex_rd;
    logic                id_serialize;

    pipe_ctrl_gen_if #(.STAGES(NS), .ISSUE_NUM(NI)) bus_a ();
    pipe_ctrl_gen_if #(.STAGES(NS), .ISSUE_NUM(NI)) bus_b ();

    assign bus_a.stall_req = stall_req;    assign bus_b.stall_req = stall_req;
    assign bus_a.flush_req = flush_req;    assign bus_b.flush_req = flush_req;
    assign bus_a.valid = valid;            assign bus_b.valid = valid;
    assign bus_a.id_rs1_en = id_rs1_en;    assign bus_b.id_rs1_en = id_rs1_en;
    assign bus_a.id_rs2_en = id_rs2_en;    assign bus_b.id_rs2_en = id_rs2_en;
    assign bus_a.id_rs1 = id_rs1;          assign bus_b.id_rs1 = id_rs1;
    assign bus_a.id_rs2 = id_rs2;          assign bus_b.id_rs2 = id_rs2;
    assign bus_a.ex_mem_read = ex_mem_read; assign bus_b.ex_mem_read = ex_mem_read;
    assign bus_a.ex_rd = ex_rd;            assign bus_b.ex_rd = ex_rd;
    assign bus_a.id_serialize = id_serialize; assign bus_b.id_serialize = id_serialize;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_a, perf_flush_a, perf_lu_a;
    logic [31:0] perf_stall_b, perf_flush_b, perf_lu_b;
`endif

    pipe_ctrl_gen #(.STAGES(NS), .ISSUE_NUM(NI), .ID_IDX(IDI), .EX_IDX(EXI), .LU_LAT(LAT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cyc (perf_stall_a)
        , .perf_flush_evt (perf_flush_a)
        , .perf_lu_evt    (perf_lu_a)
`endif
    );

    pipe_ctrl_gen #(.STAGES(NS), .ISSUE_NUM(NI), .ID_IDX(IDI), .EX_IDX(EXI), .LU_LAT(LAT_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cyc (perf_stall_b)
        , .perf_flush_evt (perf_flush_b)
        , .perf_lu_evt    (perf_lu_b)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: remaining load-use stall cycles per instance, serialize phase flags.
    int rem_a = 0, rem_b = 0;
    bit drain = 1'b0, rel = 1'b0;
    logic [31:0] pm_stall_a = 0, pm_flush = 0, pm_lu_a = 0, pm_stall_b = 0, pm_lu_b = 0;

    stall_t obs_a_stall, obs_b_stall, obs_a_flush;
    int cnt_a, cnt_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        for (int i = 0; i < NI; i++)
            for (int l = 0; l < NI; l++)
                if (ex_mem_read[i] && ex_rd[i] != 5'd0 &&
                    ((id_rs1_en[l] && id_rs1[l] == ex_rd[i]) ||
                     (id_rs2_en[l] && id_rs2[l] == ex_rd[i])))
                    return 1'b1;
        return 1'b0;
    endfunction

    function automatic int oldest_flush();
        for (int k = NS - 1; k >= 0; k--)
            if (flush_req[k]) return k;
        return -1;
    endfunction

    // Highest live stalling stage h: stages 0..h hold, h+1 gets the bubble.
    task automatic expect_vec(input bit id_req, input int fk,
                              output stall_t s, output stall_t f, output stall_t b);
        stall_t req;
        int h;
        req = stall_req;
        req[IDI] = req[IDI] | id_req;
        h = -1;
        for (int m = 0; m < NS; m++) if (req[m]) h = m;
        if (h < fk) h = -1;
        for (int j = 0; j < NS; j++) begin
            s[j] = rst || (j <= h);
            f[j] = rst || (j < fk);
            b[j] = !rst && (h >= 0) && (j == h + 1);
        end
    endtask

    function automatic int next_rem(input int rem, input int lat, input bit hit, input bit kill_id);
        int r;
        r = (rem == 0 && hit && !kill_id) ? lat : rem;
        return (r > 0) ? r - 1 : 0;
    endfunction

    task automatic step();
        bit hit, kill_id, older, ser_req;
        int fk;
        stall_t sa, fa, ba, sb, fb, bb;
        @(negedge clk);
        hit     = model_hit();
        fk      = oldest_flush();
        kill_id = fk > IDI;
        older   = |valid[NS-1:IDI+1];
        ser_req = drain || (!rel && id_serialize && older);
        expect_vec(rem_a > 0 || hit || ser_req, fk, sa, fa, ba);
        expect_vec(rem_b > 0 || hit || ser_req, fk, sb, fb, bb);
        obs_a_stall = bus_a.stall;
        obs_b_stall = bus_b.stall;
        obs_a_flush = bus_a.flush;
        chk("a.stall",  bus_a.stall,  sa);
        chk("a.flush",  bus_a.flush,  fa);
        chk("a.bubble", bus_a.bubble, ba);
        chk("b.stall",  bus_b.stall,  sb);
        chk("b.flush",  bus_b.flush,  fb);
        chk("b.bubble", bus_b.bubble, bb);
`ifdef PIPE_CTRL_PERF_EN
        chk("a.perf_stall", perf_stall_a, pm_stall_a);
        chk("a.perf_flush", perf_flush_a, pm_flush);
        chk("a.perf_lu",    perf_lu_a,    pm_lu_a);
        chk("b.perf_stall", perf_stall_b, pm_stall_b);
        chk("b.perf_flush", perf_flush_b, pm_flush);
        chk("b.perf_lu",    perf_lu_b,    pm_lu_b);
`endif
        if (rst) begin
            rem_a = 0; rem_b = 0; drain = 0; rel = 0;
            pm_stall_a = 0; pm_stall_b = 0; pm_flush = 0; pm_lu_a = 0; pm_lu_b = 0;
        end else begin
            pm_stall_a = pm_stall_a + 32'(sa[IDI]);
            pm_stall_b = pm_stall_b + 32'(sb[IDI]);
            pm_flush   = pm_flush + 32'(|flush_req);
            pm_lu_a    = pm_lu_a + 32'(rem_a == 0 && hit && !kill_id);
            pm_lu_b    = pm_lu_b + 32'(rem_b == 0 && hit && !kill_id);
            rem_a = next_rem(rem_a, LAT_A, hit, kill_id);
            rem_b = next_rem(rem_b, LAT_B, hit, kill_id);
            if (kill_id)    begin drain = 0; rel = 0; end
            else if (rel)   rel = 0;
            else if (drain) begin if (!older) begin drain = 0; rel = 1; end end
            else if (id_serialize && older) drain = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        stall_req = '0; flush_req = '0; valid = '0;
        id_rs1_en = '0; id_rs2_en = '0; id_rs1 = '0; id_rs2 = '0;
        ex_mem_read = '0; ex_rd = '0; id_serialize = 1'b0;
    endtask

    task automatic set_hit();
        ex_mem_read[0] = 1'b1; ex_rd[0] = 5'd5;
        id_rs2_en[1] = 1'b1;   id_rs2[1] = 5'd5;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        step(); step();
        rst = 1'b0;
        step();

        // Single-cycle load-use hit; count how long each instance holds ID.
        cnt_a = 0; cnt_b = 0;
        set_hit();
        step();
        chk("lu_stall_vec", obs_a_stall, 5'b00011);
        cnt_a += int'(obs_a_stall[IDI]); cnt_b += int'(obs_b_stall[IDI]);
        clear();
        repeat (4) begin
            step();
            cnt_a += int'(obs_a_stall[IDI]); cnt_b += int'(obs_b_stall[IDI]);
        end
        chk("lu_len_lat1", cnt_a, 1);
        chk("lu_len_lat3", cnt_b, 3);

        // A load to x0 is never a hazard.
        ex_mem_read[0] = 1'b1; ex_rd[0] = 5'd0; id_rs1_en[0] = 1'b1; id_rs1[0] = 5'd0;
        step();
        chk("lu_rd0", obs_b_stall, 5'b00000);
        clear();

        // EX redirect kills the ID stall.
        stall_req[1] = 1'b1; flush_req[2] = 1'b1;
        step();
        chk("exflush_flush", obs_a_flush, 5'b00011);
        chk("exflush_stall", obs_a_stall, 5'b00000);
        clear();

        // WB flush overrides a held MM stall in its cycle only.
        stall_req[3] = 1'b1;
        step();
        flush_req[4] = 1'b1;
        step();
        chk("mmflush_stall", obs_a_stall, 5'b00000);
        chk("mmflush_flush", obs_a_flush, 5'b01111);
        flush_req = '0;
        step();
        chk("mmstall_resume", obs_a_stall, 5'b01111);
        step();
        clear();

        // Serialize: drain older stages, then release ID for one cycle.
        cnt_a = 0;
        id_serialize = 1'b1;
        valid = 5'b11110; step(); cnt_a += int'(obs_a_stall[IDI]);
        valid = 5'b01110; step(); cnt_a += int'(obs_a_stall[IDI]);
        valid = 5'b00110; step(); cnt_a += int'(obs_a_stall[IDI]);
        valid = 5'b00010; step(); cnt_a += int'(obs_a_stall[IDI]);
        step();
        chk("ser_release", obs_a_stall, 5'b00000);
        chk("ser_drain_len", cnt_a, 4);
        clear();
        step();

        // A flush mid-drain returns the FSM to idle.
        id_serialize = 1'b1; valid = 5'b11110;
        step();
        flush_req[3] = 1'b1;
        step();
        clear();
        step();
        chk("ser_flush_idle", obs_a_stall, 5'b00000);

        // Reset during the LU_LAT=3 countdown aborts it.
        set_hit();
        step();
        clear();
        rst = 1'b1;
        step();
        chk("rst_stall", obs_b_stall, 5'b11111);
        rst = 1'b0;
        step();
        chk("rst_abort", obs_b_stall, 5'b00000);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int m = 0; m < NS; m++) begin
                stall_req[m] = ($urandom_range(0, 9) == 0);
                flush_req[m] = ($urandom_range(0, 19) == 0);
            end
            valid = NS'($urandom);
            for (int l = 0; l < NI; l++) begin
                id_rs1_en[l]   = $urandom_range(0, 1) == 1;
                id_rs2_en[l]   = $urandom_range(0, 1) == 1;
                id_rs1[l]      = 5'($urandom_range(0, 3));
                id_rs2[l]      = 5'($urandom_range(0, 3));
                ex_mem_read[l] = ($urandom_range(0, 3) == 0);
                ex_rd[l]       = 5'($urandom_range(0, 3));
            end
            id_serialize = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Generalised pipeline hazard and control unit for the dual-issue RV64 core. It replaces the fixed 5-stage, purely combinational stall/flush decoder with a parametrised controller. Per-stage multi-cycle stall requests, oldest-wins flush arbitration, a multi-cycle load-use interlock counter and a serialize/drain FSM are added. It sits beside the pipeline registers and drives their hold, kill and bubble controls every cycle.

## Interface
- `STAGES`, 5: pipeline stages, index 0 = IF (youngest) … STAGES-1 = WB (oldest).
- `ISSUE_NUM`, 2: issue lanes checked for load-use.
- `ID_IDX`, 1: decode stage index.
- `EX_IDX`, 2: execute stage index.
- `LU_LAT`, 1: load-use bubble cycles (1..7).
- `CNT_W`, 32: performance counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall_req` in STAGES: stage k cannot advance this cycle (level).
- `flush_req` in STAGES: stage k redirects; one-cycle pulse.
- `valid` in STAGES: stage k holds a live instruction.
- `id_rs1_en`, `id_rs2_en` in ISSUE_NUM: source-read enables per ID lane.
- `id_rs1`, `id_rs2` in ISSUE_NUM×5: source register indices per ID lane.
- `ex_mem_read` in ISSUE_NUM: EX lane is a load.
- `ex_rd` in ISSUE_NUM×5: EX lane destination register.
- `id_serialize` in 1: ID holds a serializing instruction (fence.i, CSR write).
- `stall` out STAGES: stage j holds its register.
- `flush` out STAGES: stage j register loads invalid.
- `bubble` out STAGES: stage j register loads a NOP because its feeder stalled.
- `perf_stall_cyc`, `perf_flush_evt`, `perf_lu_evt` out CNT_W each: counters, present only under the macro.

## Operation
- **Load-use hazard (`lu_hit`).** Set for any lane i where `ex_mem_read[i]`, `ex_rd[i]!=0`, and either:
  - `id_rs1_en[l]` and `id_rs1[l]==ex_rd[i]` for any lane l, or
  - the same test on rs2.
- **Load-use counter `lu_cnt`** (3 bits):
  - When `lu_cnt==0` and `lu_hit` and no flush kills ID: load `LU_LAT-1` and stall ID this cycle.
  - While `lu_cnt!=0`: stall ID, decrement, and mask `lu_hit`.
  - The total stall is exactly LU_LAT cycles per hazard.
- **Serialize FSM:**
  - IDLE → DRAIN when `id_serialize` and any `valid[m]` with m>ID_IDX.
  - DRAIN: ID stalled. Goes to RELEASE when all older `valid` are 0.
  - RELEASE: ID released for one cycle, then IDLE.
  - Any flush killing ID forces IDLE.
  - If no older stage is valid on entry, ID proceeds without stalling.
- **Effective stall `se[m]`:**
  - `stall_req[m]`, OR'd with the lu/serialize stall when m==ID_IDX.
  - Zeroed if any `flush_req[k]` with k>m, because dead instructions do not stall.
- **Outputs:**
  - `stall[j]` = OR of `se[m]` for m≥j.
  - `flush[j]` = OR of `flush_req[k]` for k>j.
  - `bubble[j]` = `stall[j-1] & ~stall[j]`; `bubble[0]`=0.
- **Flush vs stall:** when `flush[j]` and `stall[j]` are both 1, flush wins and the register loads invalid.
- **Simultaneous flushes:** the oldest stage determines the kill set.

## Timing
- Outputs are combinational from inputs and state, with zero-cycle latency.
- State updates at posedge.
- During `rst`:
  - `stall` and `flush` are all ones; `bubble` is 0.
  - `lu_cnt`=0, FSM=IDLE, counters=0.
- A reset mid-DRAIN or mid-countdown aborts cleanly to IDLE/0.
- The load-use stall starts in the same cycle `lu_hit` is first seen.

## Configuration
- `PIPE_CTRL_PERF_EN`: instantiates three saturating CNT_W counters.
  - `perf_stall_cyc` increments on each cycle with `stall[ID_IDX]` and not rst.
  - `perf_flush_evt` increments on each cycle with any `flush_req`.
  - `perf_lu_evt` increments on each new load-use detection.
- Without the macro, the perf ports and logic are absent.

## Structure
- Shared package holds:
  - stage index localparams (IF/ID/EX/MM/WB);
  - the serialize FSM enum `ser_state_t`;
  - the `stall_t`/`flush_t` widths derived from STAGES.
- Sub-module `pipe_lu_detect`: combinational ISSUE_NUM×ISSUE_NUM load-use comparator producing `lu_hit`.

## Test plan
- **Load-use, LU_LAT=1.** Lane0 `ex_rd`=5 is a load and lane1 `id_rs2`=5 is enabled, for one cycle. → `stall`=00011, `bubble[2]`=1, for exactly 1 cycle.
- **Load-use, LU_LAT=3.** Same hit. → ID stalled 3 consecutive cycles, `lu_cnt` 2,1,0. An `ex_rd`=0 load gives no stall.
- **EX flush kills ID stall.** `flush_req[2]` pulse in the same cycle as `stall_req[1]`. → `flush`=00011, `stall`=00000.
- **Flush beats MM stall.** `stall_req[3]` held 4 cycles and `flush_req[4]` in cycle 2. → `stall`=01111 in cycles 1,3,4 and 00000 in cycle 2; `flush`=01111 in cycle 2.
- **Serialize drain.** `id_serialize` with `valid`=11110, older stages draining over 3 cycles. → ID stalled until `valid[4:2]`=0, then released one cycle. A flush mid-DRAIN returns to IDLE.
- **Reset mid-countdown.** `rst` during `lu_cnt`=2. → all-ones `stall`/`flush`, `lu_cnt`=0 after release. With `PIPE_CTRL_PERF_EN`, counters read 0.
